// File: rtl/pe_stream_tx.sv
// Transmit streamer for a PE input port: buffers 2*VEC_LEN words (X then Y) and bursts them out on start.
// Optional macro PE_TX_CONJ_EN conjugates Y words (imag half negated, saturating) on the way out.
module pe_stream_tx #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned VEC_LEN    = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_v,
   input  logic [2*DATA_WIDTH-1:0] wr_data,
   output logic                    wr_ready,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    dout_pe_v,
   output logic [2*DATA_WIDTH-1:0] dout_pe
);

   localparam int unsigned WW    = 2 * DATA_WIDTH;
   localparam int unsigned DEPTH = 2 * VEC_LEN;
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   typedef enum logic [1:0] {S_FILL, S_FULL, S_SEND, S_DONE} state_t;

   state_t          r_state;
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic            r_wr_ready;
   logic            r_busy;
   logic            r_done;
   logic            r_dout_v;
   logic [WW-1:0]   r_dout;
   logic [WW-1:0]   r_buf [DEPTH];

   logic            w_wr_en;
   logic [WW-1:0]   w_rd_word;
   logic [WW-1:0]   w_tx_word;

   assign w_wr_en   = wr_v && r_wr_ready && (r_state == S_FILL);
   assign w_rd_word = r_buf[r_rd_ptr];

`ifdef PE_TX_CONJ_EN
   logic [DATA_WIDTH-1:0] w_imag;
   logic [DATA_WIDTH-1:0] w_imag_neg;

   // Y half is the upper half of the buffer, so the pointer MSB selects it.
   always_comb begin
      w_imag = w_rd_word[DATA_WIDTH-1:0];
      if (w_imag == {1'b1, {(DATA_WIDTH-1){1'b0}}})
         w_imag_neg = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
         w_imag_neg = ~w_imag + DATA_WIDTH'(1);
      w_tx_word = w_rd_word;
      if (r_rd_ptr[AW-1])
         w_tx_word[DATA_WIDTH-1:0] = w_imag_neg;
   end
`else
   assign w_tx_word = w_rd_word;
`endif

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_buf[r_wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_FILL;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wr_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_dout_v   <= 1'b0;
         r_dout     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_FILL: begin
               if (w_wr_en) begin
                  r_wr_ptr <= r_wr_ptr + AW'(1);
                  if (r_wr_ptr == LAST) begin
                     r_state    <= S_FULL;
                     r_wr_ready <= 1'b0;
                  end
               end
            end
            S_FULL: begin
               if (start) begin
                  r_state  <= S_SEND;
                  r_rd_ptr <= '0;
               end
            end
            S_SEND: begin
               r_dout_v <= 1'b1;
               r_busy   <= 1'b1;
               r_dout   <= w_tx_word;
               r_rd_ptr <= r_rd_ptr + AW'(1);
               if (r_rd_ptr == LAST)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_dout_v   <= 1'b0;
               r_busy     <= 1'b0;
               r_dout     <= '0;
               r_done     <= 1'b1;
               r_wr_ready <= 1'b1;
               r_wr_ptr   <= '0;
               r_state    <= S_FILL;
            end
            default: r_state <= S_FILL;
         endcase
      end
   end

   assign wr_ready  = r_wr_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign dout_pe_v = r_dout_v;
   assign dout_pe   = r_dout;

endmodule

// File: tb/tb_pe_stream_tx.sv
// Directed self-checking bench for pe_stream_tx (default VEC_LEN=32, DATA_WIDTH=16).
module tb_pe_stream_tx;

   localparam int VL    = 32;
   localparam int DEPTH = 2 * VL;

`ifdef PE_TX_CONJ_EN
   localparam logic [31:0] EXP_Y0 = 32'h0004_FFFE;
   localparam logic [31:0] EXP_Y1 = 32'h0003_7FFF;
`else
   localparam logic [31:0] EXP_Y0 = 32'h0004_0002;
   localparam logic [31:0] EXP_Y1 = 32'h0003_8000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_v;
   logic [31:0] wr_data;
   logic        wr_ready;
   logic        start;
   logic        busy;
   logic        done;
   logic        dout_pe_v;
   logic [31:0] dout_pe;

   int total = 0;
   int bad   = 0;

   logic [31:0] src [DEPTH];
   logic [31:0] nxt [DEPTH];
   logic [31:0] pat [8];

   logic [31:0] got  [DEPTH];
   logic [1:0]  gotv [DEPTH];
   logic        pre_v;
   logic [3:0]  done_flags;
   logic [31:0] done_dout;
   logic        post_done;

   pe_stream_tx #(.DATA_WIDTH(16), .VEC_LEN(VL)) dut (
      .clk(clk), .rst(rst), .wr_v(wr_v), .wr_data(wr_data), .wr_ready(wr_ready),
      .start(start), .busy(busy), .done(done), .dout_pe_v(dout_pe_v), .dout_pe(dout_pe)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] txform(input logic [31:0] w, input int idx);
      logic [31:0] r;
      r = w;
`ifdef PE_TX_CONJ_EN
      if (idx >= VL) begin
         if (w[15:0] == 16'h8000) r[15:0] = 16'h7FFF;
         else                     r[15:0] = 16'h0000 - w[15:0];
      end
`endif
      return r;
   endfunction

   task automatic fill(input int from, input int to);
      for (int k = from; k < to; k++) begin
         @(negedge clk);
         wr_v    = 1'b1;
         wr_data = src[k];
      end
      @(negedge clk);
      wr_v = 1'b0;
   endtask

   // Pulses start and records the burst; optionally writes nxt[] starting in the done cycle.
   task automatic run_burst(input int mid_start, input bit chain);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pre_v = dout_pe_v;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         got[i]  = dout_pe;
         gotv[i] = {dout_pe_v, busy};
         start   = (i == mid_start);
      end
      @(negedge clk);
      start      = 1'b0;
      done_flags = {done, dout_pe_v, busy, wr_ready};
      done_dout  = dout_pe;
      if (chain) begin
         wr_v    = 1'b1;
         wr_data = nxt[0];
         for (int k = 1; k < DEPTH; k++) begin
            @(negedge clk);
            if (k == 1) post_done = done;
            wr_data = nxt[k];
         end
         @(negedge clk);
         wr_v = 1'b0;
      end else begin
         @(negedge clk);
         post_done = done;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; wr_v = 1'b0; start = 1'b0; wr_data = '0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      total++;
      if ({wr_ready, dout_pe_v, busy, done, dout_pe} !== {4'b1000, 32'h0}) begin
         bad++;
         $display("FAIL reset_held got=%b_%h want=1000_00000000", {wr_ready, dout_pe_v, busy, done}, dout_pe);
      end
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({wr_ready, dout_pe_v, busy, done, dout_pe} !== {4'b1000, 32'h0}) begin
         bad++;
         $display("FAIL reset_release got=%b_%h want=1000_00000000", {wr_ready, dout_pe_v, busy, done}, dout_pe);
      end
   endtask

   task automatic test_fill_and_burst;
      logic seen;
      pat = '{32'h0004_0002, 32'h0003_0001, 32'h0008_0006, 32'h0007_0005,
              32'h000C_000A, 32'h000B_0009, 32'h0002_0001, 32'h0004_0003};
      for (int k = 0; k < DEPTH; k++) begin
         src[k] = pat[k % 8];
         nxt[k] = 32'hA500_0000 + 32'(k * 257);
      end
      fill(0, 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (dout_pe_v || busy || done || !wr_ready) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL start_in_fill got=%b want=0", seen);
      end
      fill(10, DEPTH);
      total++;
      if (wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_wr_ready got=%b want=0", wr_ready);
      end
      wr_v    = 1'b1;
      wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      wr_v = 1'b0;
      total++;
      if ({wr_ready, dout_pe_v} !== 2'b00) begin
         bad++;
         $display("FAIL write_when_full got=%b want=00", {wr_ready, dout_pe_v});
      end
      run_burst(10, 1'b1);
      total++;
      if (pre_v !== 1'b0) begin
         bad++;
         $display("FAIL burst1_latency got=%b want=0", pre_v);
      end
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if ({gotv[i], got[i]} !== {2'b11, txform(src[i], i)}) begin
            bad++;
            $display("FAIL burst1_word%0d got=%b_%h want=11_%h", i, gotv[i], got[i], txform(src[i], i));
         end
      end
      total++;
      if ({done_flags, done_dout} !== {4'b1001, 32'h0}) begin
         bad++;
         $display("FAIL burst1_done got=%b_%h want=1001_00000000", done_flags, done_dout);
      end
      total++;
      if (post_done !== 1'b0) begin
         bad++;
         $display("FAIL burst1_done_pulse got=%b want=0", post_done);
      end
      total++;
      if (wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL b2b_refill_full got=%b want=0", wr_ready);
      end
   endtask

   task automatic test_back_to_back;
      for (int k = 0; k < DEPTH; k++) src[k] = nxt[k];
      run_burst(-1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if ({gotv[i], got[i]} !== {2'b11, txform(nxt[i], i)}) begin
            bad++;
            $display("FAIL burst2_word%0d got=%b_%h want=11_%h", i, gotv[i], got[i], txform(nxt[i], i));
         end
      end
      total++;
      if ({done_flags, post_done} !== 5'b10010) begin
         bad++;
         $display("FAIL burst2_done got=%b want=10010", {done_flags, post_done});
      end
   endtask

   task automatic test_reset_mid_send;
      logic seen;
      for (int k = 0; k < DEPTH; k++) begin
         src[k] = pat[k % 8];
         nxt[k] = 32'h3C00_0000 + 32'(k * 3);
      end
      fill(0, DEPTH);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i <= 20; i++) @(negedge clk);
      total++;
      if ({dout_pe_v, dout_pe} !== {1'b1, txform(src[20], 20)}) begin
         bad++;
         $display("FAIL mid_send_word20 got=%b_%h want=1_%h", dout_pe_v, dout_pe, txform(src[20], 20));
      end
      rst = 1'b1;
      #1;
      total++;
      if ({dout_pe_v, busy, done, wr_ready, dout_pe} !== {4'b0001, 32'h0}) begin
         bad++;
         $display("FAIL async_reset got=%b_%h want=0001_00000000", {dout_pe_v, busy, done, wr_ready}, dout_pe);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL post_reset_wr_ready got=%b want=1", wr_ready);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < DEPTH; k++) src[k] = nxt[k];
      fill(0, DEPTH - 1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 1'b0;
      repeat (DEPTH + 4) begin
         @(negedge clk);
         if (dout_pe_v || done || busy) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL start_before_refill got=%b want=0", seen);
      end
      fill(DEPTH - 1, DEPTH);
      total++;
      if (wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL refill_full got=%b want=0", wr_ready);
      end
      run_burst(-1, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
         total++;
         if ({gotv[i], got[i]} !== {2'b11, txform(nxt[i], i)}) begin
            bad++;
            $display("FAIL burst3_word%0d got=%b_%h want=11_%h", i, gotv[i], got[i], txform(nxt[i], i));
         end
      end
   endtask

   task automatic test_conj;
      for (int k = 0; k < DEPTH; k++) src[k] = '0;
      src[0]  = 32'h0004_0002;
      src[VL] = 32'h0004_0002;
      src[VL+1] = 32'h0003_8000;
      fill(0, DEPTH);
      run_burst(-1, 1'b0);
      total++;
      if (got[0] !== 32'h0004_0002) begin
         bad++;
         $display("FAIL conj_x0 got=%h want=00040002", got[0]);
      end
      total++;
      if (got[VL] !== EXP_Y0) begin
         bad++;
         $display("FAIL conj_y0 got=%h want=%h", got[VL], EXP_Y0);
      end
      total++;
      if (got[VL+1] !== EXP_Y1) begin
         bad++;
         $display("FAIL conj_y1_sat got=%h want=%h", got[VL+1], EXP_Y1);
      end
      total++;
      if ({gotv[VL+2], got[VL+2]} !== {2'b11, 32'h0}) begin
         bad++;
         $display("FAIL conj_y2_zero got=%b_%h want=11_00000000", gotv[VL+2], got[VL+2]);
      end
   endtask

   initial begin
      test_reset();
      test_fill_and_burst();
      test_back_to_back();
      test_reset_mid_send();
      test_conj();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
